// File: rtl/logic_slice_sched.sv
`default_nettype none
// ============================================================================
// Module   : logic_slice_sched
// Brief    : Two-requester round-robin scheduler around a shared SLICE-bit
//            bitwise logic stage (AND/OR/XOR/XNOR). A WIDTH-bit operation
//            is sequenced one slice per cycle. The assembled result is
//            returned with the requester id over a valid/ready response port.
// Options  : LOGIC_SCHED_STATS_EN adds an 8-bit wrapping count of completed
//            response handshakes on output done_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module logic_slice_sched #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy
`ifdef LOGIC_SCHED_STATS_EN
  ,
  output logic [7:0]       done_cnt
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             last_grant;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             sel_id;
  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_res;
  logic [WIDTH-1:0] res_next;

  // Round-robin arbitration: a lone requester wins; on a tie the one not
  // granted last time wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  assign req0_ready = (state == ST_IDLE) & grant0;
  assign req1_ready = (state == ST_IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;
  assign sel_id     = req1_ready;
  assign busy       = (state != ST_IDLE);

  // Split the latched operands into per-slice views for the slice mux.
  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    assign a_sl[i] = a_q[i*SLICE +: SLICE];
    assign b_sl[i] = b_q[i*SLICE +: SLICE];
  end

  assign slice_a = a_sl[cnt];
  assign slice_b = b_sl[cnt];

  // Shared logic stage operating on the current slice.
  always_comb begin
    slice_res = '0;
    case (op_q)
      2'b00:   slice_res = slice_a & slice_b;
      2'b01:   slice_res = slice_a | slice_b;
      2'b10:   slice_res = slice_a ^ slice_b;
      default: slice_res = ~(slice_a ^ slice_b);
    endcase
  end

  // Merge the new slice into the result; all other slices keep their value.
  always_comb begin
    res_next = rsp_result;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) begin
        res_next[i*SLICE +: SLICE] = slice_res;
      end
    end
  end

  // Control FSM, operand capture and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_q       <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= sel_id ? req1_op : req0_op;
            a_q        <= sel_id ? req1_a  : req0_a;
            b_q        <= sel_id ? req1_b  : req0_b;
            rsp_id     <= sel_id;
            last_grant <= sel_id;
            rsp_result <= '0;
            cnt        <= '0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          rsp_result <= res_next;
          if (cnt == CW'(NSLICE - 1)) begin
            rsp_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Result, id and valid hold until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOGIC_SCHED_STATS_EN
  // Count completed response handshakes; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= 8'd0;
    end else if (rsp_valid && rsp_ready) begin
      done_cnt <= done_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_slice_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_slice_sched
// Brief    : Directed self-checking bench for logic_slice_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_slice_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] rsp_result;
`ifdef LOGIC_SCHED_STATS_EN
  logic [7:0]  done_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic_slice_sched #(.WIDTH(16), .SLICE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
`ifdef LOGIC_SCHED_STATS_EN
    ,
    .done_cnt   (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for rsp_valid; n = edges waited, or -1 on timeout.
  task automatic wait_valid(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) n = -1;
  endtask

  task automatic set_req0(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
  endtask

  task automatic set_req1(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
    set_req0(2'b00, 16'h1234, 16'h5678);
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", rsp_result); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %b expected 0", rsp_id); end
    rst_n = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready0: got %b expected 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready1: got %b expected 0", req1_ready); end
    req0_valid = 1'b0;
    #1;
  endtask

  task automatic test_single_xor();
    int n;
    int bc;
    set_req0(2'b10, 16'hDDDD, 16'h7777);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL xor_ready: got %b expected 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    n = 0; bc = 0;
    while (!rsp_valid && n < 20) begin
      if (busy) bc++;
      tick();
      n++;
    end
    if (busy) bc++;
    checks++; if (n !== 4) begin errors++; $display("FAIL xor_latency: got %0d edges expected 4", n); end
    checks++; if (rsp_result !== 16'hAAAA) begin errors++; $display("FAIL xor_result: got %h expected aaaa", rsp_result); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL xor_id: got %b expected 0", rsp_id); end
    tick();
    checks++; if (bc !== 5) begin errors++; $display("FAIL xor_busy_cycles: got %0d expected 5", bc); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL xor_after_hs: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    checks++; if (rsp_result !== 16'hAAAA) begin errors++; $display("FAIL xor_result_hold: got %h expected aaaa", rsp_result); end
  endtask

  task automatic test_arbitration();
    int n;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req0(2'b00, 16'hF0F0, 16'hFFFF);
    set_req1(2'b01, 16'h000F, 16'h0F00);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL arb_first_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL arb_run_ready1: got %b expected 0", req1_ready); end
    wait_valid(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL arb_lat0: got %0d expected 4", n); end
    checks++; if (rsp_id !== 1'b0 || rsp_result !== 16'hF0F0) begin errors++; $display("FAIL arb_rsp0: got id=%b res=%h expected 0 f0f0", rsp_id, rsp_result); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL arb_done_ready1: got %b expected 0", req1_ready); end
    tick();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL arb_idle_ready1: got %b expected 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    wait_valid(n);
    checks++; if (rsp_id !== 1'b1 || rsp_result !== 16'h0F0F) begin errors++; $display("FAIL arb_rsp1: got id=%b res=%h expected 1 0f0f", rsp_id, rsp_result); end
    tick();
    set_req0(2'b00, 16'hFFFF, 16'h1234);
    set_req1(2'b01, 16'h1111, 16'h2222);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL arb_rr_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_valid(n);
    checks++; if (rsp_id !== 1'b0 || rsp_result !== 16'h1234) begin errors++; $display("FAIL arb_rsp2: got id=%b res=%h expected 0 1234", rsp_id, rsp_result); end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    set_req0(2'b11, 16'hAAAA, 16'hAAAA);
    #1;
    tick();
    req0_valid = 1'b0;
    set_req1(2'b00, 16'h5555, 16'h5555);
    #1;
    wait_valid(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 16'hFFFF || rsp_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b res=%h id=%b r0=%b r1=%b expected 1 ffff 0 0 0", i, rsp_valid, rsp_result, rsp_id, req0_ready, req1_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    checks++; if (rsp_result !== 16'hFFFF) begin errors++; $display("FAIL bp_result_hold: got %h expected ffff", rsp_result); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready1: got %b expected 1", req1_ready); end
    req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_equal_operands();
    int n;
    set_req0(2'b10, 16'hAAAA, 16'hAAAA);
    #1;
    tick();
    checks++; if (rsp_result !== 16'h0000) begin errors++; $display("FAIL eq_cleared: got %h expected 0000", rsp_result); end
    req0_valid = 1'b0;
    req0_op = 2'b11; req0_a = 16'hFFFF; req0_b = 16'h0000;
    wait_valid(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL eq_latency: got %0d expected 4", n); end
    checks++; if (rsp_result !== 16'h0000 || rsp_id !== 1'b0) begin errors++; $display("FAIL eq_result: got res=%h id=%b expected 0000 0", rsp_result, rsp_id); end
    tick();
  endtask

  task automatic test_mid_reset();
    int n;
    bit seen;
    set_req0(2'b00, 16'hFFFF, 16'hFFFF);
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_result !== 16'h0000) begin errors++; $display("FAIL midrst_abort: got busy=%b valid=%b res=%h expected 0 0 0000", busy, rsp_valid, rsp_result); end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp: got %b expected 0", seen); end
`ifdef LOGIC_SCHED_STATS_EN
    checks++; if (done_cnt !== 8'd0) begin errors++; $display("FAIL stats_reset: got %0d expected 0", done_cnt); end
`endif
    set_req0(2'b00, 16'hFFFF, 16'h00FF);
    set_req1(2'b01, 16'h0F00, 16'h00F0);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL midrst_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0;
    wait_valid(n);
    checks++; if (rsp_id !== 1'b0 || rsp_result !== 16'h00FF) begin errors++; $display("FAIL post_rsp0: got id=%b res=%h expected 0 00ff", rsp_id, rsp_result); end
    tick();
    tick();
    req1_valid = 1'b0;
    wait_valid(n);
    checks++; if (rsp_id !== 1'b1 || rsp_result !== 16'h0FF0) begin errors++; $display("FAIL post_rsp1: got id=%b res=%h expected 1 0ff0", rsp_id, rsp_result); end
    tick();
`ifdef LOGIC_SCHED_STATS_EN
    checks++; if (done_cnt !== 8'd2) begin errors++; $display("FAIL stats_count: got %0d expected 2", done_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_xor();
    test_arbitration();
    test_backpressure();
    test_equal_operands();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
